// File: rtl/sr_sequencer.sv
// sr_sequencer
//   Command sequencer that sits directly upstream of an 8-bit shift register (sr).
//   It accepts one job (word, direction, shift count) over a valid/ready handshake.
//   It drives the sr with one parallel-load cycle followed by N shift cycles.
//   It then samples the sr output and returns it over a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock, shared with the sr
//   rst_n      asynchronous active-low reset
//   in_valid   job request
//   in_ready   high only while idle; a job is taken on in_valid && in_ready
//   in_data    word to parallel-load into the sr
//   in_dir     0 = shift right, 1 = shift left
//   in_count   number of shifts; values above WIDTH saturate to WIDTH
//   shift      sr shift code (hold / right / left / load)
//   d          sr parallel-load data
//   sr_q       sr output (registered inside the sr)
//   out_valid  result available
//   out_ready  result consumer ready
//   out_data   sr_q sampled after the last shift
//   busy       high whenever a job is in flight
//   done       one-cycle pulse on the cycle after the result handshake

module sr_sequencer #(
  parameter int         WIDTH     = 8,
  parameter int         CNT_W     = 4,
  parameter logic [1:0] CODE_HOLD = 2'd0,
  parameter logic [1:0] CODE_SHR  = 2'd1,
  parameter logic [1:0] CODE_SHL  = 2'd2,
  parameter logic [1:0] CODE_LOAD = 2'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_count,
  output logic [1:0]       shift,
  output logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] sr_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] data_r;
  logic             dir_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_sat_s;
  logic [WIDTH-1:0] out_data_r;
  logic             done_r;

  assign cnt_sat_s = (in_count > CNT_MAX) ? CNT_MAX : in_count;
  assign out_data  = out_data_r;
  assign done      = done_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A zero-count job is a pure load; skip the shift phase entirely.
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_CAPTURE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // cnt_r counts shifts still to issue, including the current one.
        if (cnt_r == CNT_ONE) begin
          state_s = ST_CAPTURE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_CAPTURE: state_s = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Job latches, shift counter, result register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r     <= {WIDTH{1'b0}};
      dir_r      <= 1'b0;
      cnt_r      <= CNT_ZERO;
      out_data_r <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && in_valid) begin
        data_r <= in_data;
        dir_r  <= in_dir;
        cnt_r  <= cnt_sat_s;
      end else if (state_r == ST_SHIFT) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
      // The sr has applied its last shift by the CAPTURE cycle.
      if (state_r == ST_CAPTURE) begin
        out_data_r <= sr_q;
      end
      done_r <= (state_r == ST_OUT) && out_ready;
    end
  end

  // Output decode from the registered state only.
  always_comb begin
    shift     = CODE_HOLD;
    d         = {WIDTH{1'b0}};
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_LOAD: begin
        shift = CODE_LOAD;
        d     = data_r;
      end
      ST_SHIFT: begin
        shift = dir_r ? CODE_SHL : CODE_SHR;
        d     = data_r;
      end
      ST_CAPTURE: begin
        d = data_r;
      end
      ST_OUT: begin
        d         = data_r;
        out_valid = 1'b1;
      end
      default: begin
        shift = CODE_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_sequencer.sv
// tb_sr_sequencer
//   Directed bench for sr_sequencer driving a zero-fill 8-bit shift register model.
//   An elapsed-cycle job model predicts every output on every cycle.
//   Literal expectations pin result words, latencies and the shift sequence.

module tb_sr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dir;
  logic [3:0] in_count;
  logic [1:0] shift;
  logic [7:0] d;
  logic [7:0] sr_q = 8'h00;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic chk_en = 1'b0;

  sr_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_count  (in_count),
    .shift     (shift),
    .d         (d),
    .sr_q      (sr_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure latencies.
  always @(posedge clk) cyc <= cyc + 1;

  // Zero-fill shift register the sequencer drives.
  always @(posedge clk) begin
    case (shift)
      2'd3:    sr_q <= d;
      2'd1:    sr_q <= {1'b0, sr_q[7:1]};
      2'd2:    sr_q <= {sr_q[6:0], 1'b0};
      default: sr_q <= sr_q;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] shifted(input logic [7:0] v, input logic dir, input int n);
    int w;
    w = int'(v);
    for (int i = 0; i < n; i++) w = dir ? w * 2 : w / 2;
    return 8'(w % 256);
  endfunction

  // Job model: phase = cycles elapsed since acceptance (0 = idle).
  // Phase 1 is the load, 2..n+1 the shifts, n+2 capture, n+3 result offered.
  int         m_phase = 0;
  int         m_n     = 0;
  logic [7:0] m_data  = 8'h00;
  logic       m_dir   = 1'b0;
  logic [7:0] m_res   = 8'h00;
  logic       m_done  = 1'b0;

  // Advance the job model on every edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_phase == 0) begin
        if (in_valid) begin
          m_n     <= (int'(in_count) > 8) ? 8 : int'(in_count);
          m_data  <= in_data;
          m_dir   <= in_dir;
          m_res   <= shifted(in_data, in_dir, (int'(in_count) > 8) ? 8 : int'(in_count));
          m_phase <= 1;
        end
      end else if (m_phase < m_n + 3) begin
        m_phase <= m_phase + 1;
      end else if (out_ready) begin
        m_phase <= 0;
        m_done  <= 1'b1;
      end
    end
  end

  logic [1:0] e_shift;
  logic       e_ov;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_phase == 0)               e_shift = 2'd0;
      else if (m_phase == 1)          e_shift = 2'd3;
      else if (m_phase <= m_n + 1)    e_shift = m_dir ? 2'd2 : 2'd1;
      else                            e_shift = 2'd0;
      e_ov = (m_phase != 0) && (m_phase == m_n + 3);
      check("shift", 32'(shift), 32'(e_shift));
      check("d", 32'(d), (m_phase == 0) ? 32'h0 : 32'(m_data));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("in_ready", 32'(in_ready), 32'(m_phase == 0));
      check("out_valid", 32'(out_valid), 32'(e_ov));
      check("done", 32'(done), 32'(m_done));
      if (e_ov) check("out_data", 32'(out_data), 32'(m_res));
    end
  end

  logic [1:0] shq[$];

  task automatic drive(input logic [7:0] v, input logic dir, input logic [3:0] cnt);
    in_valid = 1'b1;
    in_data  = v;
    in_dir   = dir;
    in_count = cnt;
  endtask

  task automatic wait_accept(output int e0);
    bit found = 1'b0;
    e0 = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_phase == 1) begin
        found = 1'b1;
        e0 = cyc;
      end
    end
    if (!found) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Returns the first edge (relative to e0) at which out_valid is seen high.
  task automatic wait_out(input int e0, output int lat);
    bit found = 1'b0;
    lat = -1;
    shq.delete();
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      shq.push_back(shift);
      if (out_valid) begin
        found = 1'b1;
        lat = cyc + 1 - e0;
      end
    end
    if (!found) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic handshake_done();
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("ready_after_hs", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    int e0, e1, lat, x, nshl;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dir = 1'b0;
    in_count = 4'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_shift", 32'(shift), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: 3F right by 2
    @(posedge clk); #1;
    drive(8'h3F, 1'b0, 4'd2);
    wait_accept(e0);
    in_valid = 1'b0;
    wait_out(e0, lat);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_data", 32'(out_data), 32'h0F);
    if (shq.size() >= 4) begin
      check("t1_seq0", 32'(shq[0]), 32'd3);
      check("t1_seq1", 32'(shq[1]), 32'd1);
      check("t1_seq2", 32'(shq[2]), 32'd1);
      check("t1_seq3", 32'(shq[3]), 32'd0);
    end else begin
      check("t1_seq_len", 32'(shq.size()), 32'd4);
    end
    handshake_done();

    // 2: count 0 is a pure load
    @(posedge clk); #1;
    drive(8'hA5, 1'b0, 4'd0);
    wait_accept(e0);
    in_valid = 1'b0;
    wait_out(e0, lat);
    check("t2_latency", 32'(lat), 32'd3);
    check("t2_data", 32'(out_data), 32'hA5);
    handshake_done();

    // 3: count 12 saturates to 8 left shifts
    @(posedge clk); #1;
    drive(8'hFF, 1'b1, 4'd12);
    wait_accept(e0);
    in_valid = 1'b0;
    wait_out(e0, lat);
    check("t3_latency", 32'(lat), 32'd11);
    check("t3_data", 32'(out_data), 32'h00);
    nshl = 0;
    foreach (shq[i]) if (shq[i] == 2'd2) nshl++;
    check("t3_shl_count", 32'(nshl), 32'd8);
    handshake_done();

    // 4: consumer stalls for 10 cycles
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(8'h3C, 1'b1, 4'd1);
    wait_accept(e0);
    in_valid = 1'b0;
    wait_out(e0, lat);
    check("t4_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_valid_held", 32'(out_valid), 32'd1);
      check("t4_data_held", 32'(out_data), 32'h78);
      check("t4_ready_low", 32'(in_ready), 32'd0);
      check("t4_shift_hold", 32'(shift), 32'd0);
    end
    out_ready = 1'b1;
    handshake_done();

    // 5: in_valid held across two jobs
    @(posedge clk); #1;
    drive(8'h81, 1'b0, 4'd1);
    wait_accept(e0);
    drive(8'h81, 1'b1, 4'd1);
    wait_out(e0, lat);
    check("t5a_latency", 32'(lat), 32'd4);
    check("t5a_data", 32'(out_data), 32'h40);
    x = cyc;
    wait_accept(e1);
    in_valid = 1'b0;
    check("t5b_accept_edge", 32'(e1 - x), 32'd2);
    wait_out(e1, lat);
    check("t5b_latency", 32'(lat), 32'd4);
    check("t5b_data", 32'(out_data), 32'h02);
    handshake_done();

    // 6: reset during the third shift of a 5-shift job
    @(posedge clk); #1;
    drive(8'hF0, 1'b0, 4'd5);
    wait_accept(e0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("t6_pre_shift", 32'(shift), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_shift", 32'(shift), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd1);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(8'h96, 1'b0, 4'd3);
    wait_accept(e0);
    in_valid = 1'b0;
    wait_out(e0, lat);
    check("t6_latency", 32'(lat), 32'd6);
    check("t6_data", 32'(out_data), 32'h12);
    handshake_done();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
